my_keyboard: RTL
================

# my_keyboard

- PS/2 keyboard front end that produces the 16-bit Hack key code.
- Its output drives the memory-mapped keyboard register at address 24576 (15'b110000000000000), the word the memory block returns for that address.
- Deserialises PS/2 frames and tracks E0/F0 prefixes.
- Holds the Hack code of the currently pressed key; returns to 0 when that key is released.

## Interface
Parameters:
- TIMEOUT, 25000, clk cycles allowed between PS/2 falling edges inside a frame before it is abandoned
- SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high
- ps2_clk  input  1  asynchronous PS/2 clock from device
- ps2_data  input  1  asynchronous PS/2 data from device
- out  output  16  Hack key code of the held key, 0 when none
- rx_valid  output  1  one-cycle pulse when a frame is accepted
- rx_byte  output  8  last accepted scan byte, valid while rx_valid is high
- err  output  1  one-cycle pulse on parity error, bad stop bit, or timeout

## Operation
**Front end**
- ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
- A falling edge is "previous synced ps2_clk = 1, current = 0"; it samples synced ps2_data.

**Frame FSM, states IDLE → DATA → PARITY → STOP → IDLE**
- IDLE:
  - Edge with data 0 → DATA; bit count 0; timeout counter cleared.
  - Edge with data 1 is ignored, with no err.
- DATA: 8 edges; bits shift in LSB first.
- PARITY: the parity bit must make the 9 bits (data + parity) odd-weight.
- STOP: the stop bit must be 1.
  - Good frame: rx_byte is loaded and rx_valid pulses.
  - Bad parity or bad stop: err pulses, the byte is discarded, state → IDLE.
- Timeout:
  - Outside IDLE, the counter increments every cycle and clears on each edge.
  - Reaching TIMEOUT: err pulses, state → IDLE, partial byte dropped.

**Decoder** (acts on each accepted byte)
- 0xE0 sets ext. 0xF0 sets brk. Neither changes out.
- Any other byte is a code byte; ext and brk are cleared after it is processed.
- Make (brk=0), table lookup on {ext, code}:
  - Unmapped → ignore.
  - Mapped → out = code; held = {ext, code}.
  - A new mapped make replaces the held key.
- Break (brk=1):
  - {ext, code} == held → out = 0, held cleared.
  - Otherwise → no change.
- On err, ext and brk are cleared.
- Table, non-extended scan code set 2:
  - A–Z → 65–90, e.g. 0x1C→65, 0x1A→90.
  - 0–9 → 48–57, e.g. 0x45→48, 0x16→49.
  - 0x29→32 space, 0x5A→128 enter, 0x66→129 backspace, 0x76→140 esc.
- Table, extended (E0 prefix):
  - 0x6B→130 left, 0x75→131 up, 0x74→132 right, 0x72→133 down.
  - 0x6C→134 home, 0x69→135 end.
- Same code byte with and without E0 are distinct keys, e.g. E0 72 (down) ≠ 72.

## Timing
- Reset values: out=0, rx_valid=0, rx_byte=0, err=0; FSM in IDLE; ext=brk=0; held cleared; timeout counter 0.
- Reset dominates every simultaneous event. Reset mid-frame discards the frame; no err pulse.
- Edge detect: a falling edge is detected SYNC_STAGES+1 clk cycles after the pin edge.
- Frame accept: rx_valid/rx_byte are asserted the cycle after the stop-bit edge is detected.
- out: updates on the clock edge after the rx_valid cycle, so out is 2 cycles after the stop-bit edge detection.
- err: asserts the cycle after the failing edge or timeout expiry; never asserts in the same cycle as rx_valid.
- Back-to-back frames with zero idle time are accepted.

## Test plan
- Reset, then frame 0x1C with PS/2 bit period 40 clk (20 low / 20 high) → rx_valid once with rx_byte=0x1C; out=65 two cycles later; out stays 65. Then F0, 1C → out=0.
- E0 75 → out=131. Then plain 75 → out unchanged at 131. Then E0 F0 75 → out=0.
- Press 0x1C (65), then 0x32 (66) → out=66. Break 1C → out stays 66. Break 32 → out=0.
- Frame 0x1C with inverted parity → err pulses once, no rx_valid, out unchanged. Same with stop bit 0 → same response. Next good frame is accepted normally.
- Stop ps2_clk after 4 data bits, TIMEOUT=200 → err pulses 200–201 cycles after the last edge; FSM returns to IDLE; a following good 0x45 frame gives out=48.
- reset=1 for one cycle mid-frame while out=65 → out=0 next cycle, no err. Remaining edges of the broken frame: if the next sampled bit is 1 it is ignored; the next full frame decodes correctly.

Source files
------------

// File: rtl/my_keyboard.sv
// my_keyboard: PS/2 receiver and scan-code decoder that
// produces the Hack keyboard register word (address 24576).
module my_keyboard #(
    parameter int TIMEOUT     = 25000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       err_q, err_d;

    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [8:0]  held_q, held_d;
    logic        held_vld_q, held_vld_d;
    logic [15:0] out_q, out_d;

    logic       fall;
    logic       bit_in;
    logic       timeout;
    logic [8:0] key;
    logic [8:0] hit;

    // Returns {mapped, hack_code} for an {ext, scan} key.
    function automatic logic [8:0] lookup(input logic [8:0] k);
        logic [8:0] r;
        r = '0;
        case (k)
            9'h01C: r = {1'b1, 8'd65};
            9'h032: r = {1'b1, 8'd66};
            9'h021: r = {1'b1, 8'd67};
            9'h023: r = {1'b1, 8'd68};
            9'h024: r = {1'b1, 8'd69};
            9'h02B: r = {1'b1, 8'd70};
            9'h034: r = {1'b1, 8'd71};
            9'h033: r = {1'b1, 8'd72};
            9'h043: r = {1'b1, 8'd73};
            9'h03B: r = {1'b1, 8'd74};
            9'h042: r = {1'b1, 8'd75};
            9'h04B: r = {1'b1, 8'd76};
            9'h03A: r = {1'b1, 8'd77};
            9'h031: r = {1'b1, 8'd78};
            9'h044: r = {1'b1, 8'd79};
            9'h04D: r = {1'b1, 8'd80};
            9'h015: r = {1'b1, 8'd81};
            9'h02D: r = {1'b1, 8'd82};
            9'h01B: r = {1'b1, 8'd83};
            9'h02C: r = {1'b1, 8'd84};
            9'h03C: r = {1'b1, 8'd85};
            9'h02A: r = {1'b1, 8'd86};
            9'h01D: r = {1'b1, 8'd87};
            9'h022: r = {1'b1, 8'd88};
            9'h035: r = {1'b1, 8'd89};
            9'h01A: r = {1'b1, 8'd90};
            9'h045: r = {1'b1, 8'd48};
            9'h016: r = {1'b1, 8'd49};
            9'h01E: r = {1'b1, 8'd50};
            9'h026: r = {1'b1, 8'd51};
            9'h025: r = {1'b1, 8'd52};
            9'h02E: r = {1'b1, 8'd53};
            9'h036: r = {1'b1, 8'd54};
            9'h03D: r = {1'b1, 8'd55};
            9'h03E: r = {1'b1, 8'd56};
            9'h046: r = {1'b1, 8'd57};
            9'h029: r = {1'b1, 8'd32};
            9'h05A: r = {1'b1, 8'd128};
            9'h066: r = {1'b1, 8'd129};
            9'h076: r = {1'b1, 8'd140};
            9'h16B: r = {1'b1, 8'd130};
            9'h175: r = {1'b1, 8'd131};
            9'h174: r = {1'b1, 8'd132};
            9'h172: r = {1'b1, 8'd133};
            9'h16C: r = {1'b1, 8'd134};
            9'h169: r = {1'b1, 8'd135};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        clk_sync_d    = clk_sync_q;
        dat_sync_d    = dat_sync_q;
        clk_sync_d[0] = ps2_clk;
        dat_sync_d[0] = ps2_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_d[i] = clk_sync_q[i-1];
            dat_sync_d[i] = dat_sync_q[i-1];
        end
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    end

    assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign bit_in  = dat_sync_q[SYNC_STAGES-1];
    assign timeout = (state_q != IDLE) && !fall
                     && (tmo_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!bit_in) state_d = DATA;
                DATA:    if (bit_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        err_d      = 1'b0;
        tmo_d      = (state_q == IDLE || fall) ? '0 : tmo_q + CW'(1);
        if (timeout) begin
            err_d = 1'b1;
            tmo_d = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: bit_d = 3'd0;
                DATA: begin
                    shift_d = {bit_in, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
                PARITY: par_ok_d = ^{shift_q, bit_in};
                STOP: begin
                    if (bit_in && par_ok_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign key = {ext_q, rx_byte_q};
    assign hit = lookup(key);

    // Prefix bytes only arm flags; code bytes consume them.
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        out_d      = out_q;
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid_q) begin
            if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!brk_q) begin
                    if (hit[8]) begin
                        out_d      = {8'h00, hit[7:0]};
                        held_d     = key;
                        held_vld_d = 1'b1;
                    end
                end else if (held_vld_q && key == held_q) begin
                    out_d      = '0;
                    held_vld_d = 1'b0;
                end
            end
        end
    end

    // Synchronisers clear low so a reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            err_q      <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            out_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            err_q      <= err_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            out_q      <= out_d;
        end
    end

    assign out      = out_q;
    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign err      = err_q;

endmodule
